repacker_n_lanes: RTL and testbench
===================================

Name: repacker_n_lanes

Overview:
Parametrised successor to the fixed 4-byte lane repacker. It accepts 32-bit packet words with byte strobes from the packet assembler and redistributes the bytes across a runtime-selectable number of DSI data lanes, from 1 to MAX_LANES. A byte FIFO sits between the two sides. Per-lane last-byte flags are generated so each lane's serializer can end its HS burst on its own final byte.

Parameters:
MAX_LANES, 4, number of physical lanes; legal range 1..4.
BUF_BYTES, 16, byte FIFO depth; power of two, at least 2*MAX_LANES+4.

Ports:
clk  input  1  single clock
rst  input  1  reset, synchronous, active-high
lanes_number  input  2  active lanes minus 1; values at or above MAX_LANES clamp to MAX_LANES
ln_data_rqst  input  1  lanes accept the presented beat this cycle
ln_write_data  output  8*MAX_LANES  byte i drives lane i (bits 8i+7:8i)
ln_write_rqst  output  MAX_LANES  lane i byte valid
ln_last_word  output  MAX_LANES  lane i byte is that lane's final byte of the packet
rpck_write_data  input  32  packet word; byte 0 is first on the wire
rpck_write_strb  input  4  byte enables; must be contiguous from bit 0 (1,3,7,F)
rpck_write_rqst  input  1  word valid
rpck_last_word  input  1  word is last of packet
rpck_data_rqst  output  1  repacker can accept a word this cycle
strb_err  output  1  sticky illegal-strobe flag

Behaviour:
- Reset (clk is the only clock; rst is synchronous, active-high): FIFO empty, count 0, all outputs 0, strb_err 0, latched lane count L = 1. A reset mid-packet discards all buffered bytes; there is no partial output afterwards.
- Input handshake: a word is accepted when rpck_write_rqst && rpck_data_rqst.
  - rpck_data_rqst = !tail_held && (BUF_BYTES - count >= 4).
  - It is decoded from registered state only; there is no combinational path from rpck_write_rqst.
- Accepted word: the strobed bytes are written into the FIFO in order, byte 0 first.
- Illegal strobe (0, or non-contiguous): strb_err sets and the word is dropped. The word's rpck_last_word is still honoured as the packet end.
- tail_held: sets on acceptance of a word with rpck_last_word = 1. It clears when the FIFO drains to empty. At most one packet end is ever buffered.
- Lane count: L is latched from lanes_number when count = 0 and no beat is pending. Changes mid-packet are ignored.
- Beat presentation:
  - Condition for a beat: (tail_held && count > 0) || count >= 2L.
  - Beat size: k = min(count, L).
  - Outputs: ln_write_rqst[i] = 1 for i < k. ln_write_data holds FIFO bytes 0..k-1. Unused lanes are 0.
  - Without a buffered tail, at least 2L bytes are needed so the last flags can be decided.
- ln_last_word[i]: asserted for i < k when tail_held && R <= L + i. R is the number of bytes remaining in the packet, which equals count while tail_held.
- Output handshake:
  - The beat is held stable until ln_data_rqst = 1 while any ln_write_rqst bit is set.
  - On acceptance, k bytes are popped and the next beat appears the following cycle. This gives 1 beat per cycle sustained.
  - ln_data_rqst while no beat is presented is ignored.
- Simultaneous push and pop: the count update is count + pushed - popped in the same cycle. Free space is computed from the registered count, so there is no same-cycle credit.
- Latency: a word accepted in cycle t is visible on the lanes no earlier than t+1.
- FIFO pointers wrap modulo BUF_BYTES. The count never exceeds BUF_BYTES; this is an assertion in verification.

Test Plan:
- L=4; push 0x44332211 strb F, then 0x00006655 strb 3 last -> beat1 data 0x44332211, wr 1111, last 1100; beat2 data 0x00006655, wr 0011, last 0011; rpck_data_rqst returns to 1 after drain.
- L=2; 5-byte packet AA..EE (strb F, then strb 1 last) -> beats (AA,BB) wr 11 last 00; (CC,DD) wr 11 last 10; (EE) wr 01 last 01.
- L=1; 3-byte packet strb 7 last -> three single-byte beats; ln_last_word[0]=1 only on the third.
- L=4; hold ln_data_rqst=0 for 10 cycles with words pending -> output stable; rpck_data_rqst drops once count > 12; no bytes lost or duplicated after release.
- strb 0101 accepted -> strb_err=1 and stays 1; word dropped; remaining bytes delivered normally.
- rst asserted mid-packet with 6 bytes buffered -> next cycle wr=0, last=0, count=0, rpck_data_rqst=1; next packet is clean.

Source files
------------

// File: rtl/repacker_n_lanes.sv
// Byte-lane repacker: accepts 32-bit strobed packet words and redistributes the
// bytes across 1..MAX_LANES DSI lanes through a byte FIFO. It also flags each
// lane's final byte of the packet.
module repacker_n_lanes #(
    parameter int MAX_LANES = 4,
    parameter int BUF_BYTES = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             lanes_number,
    input  logic                   ln_data_rqst,
    output logic [8*MAX_LANES-1:0] ln_write_data,
    output logic [MAX_LANES-1:0]   ln_write_rqst,
    output logic [MAX_LANES-1:0]   ln_last_word,
    input  logic [31:0]            rpck_write_data,
    input  logic [3:0]             rpck_write_strb,
    input  logic                   rpck_write_rqst,
    input  logic                   rpck_last_word,
    output logic                   rpck_data_rqst,
    output logic                   strb_err
);

    localparam int PW = $clog2(BUF_BYTES);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] BUF_CNT = CW'(BUF_BYTES);
    localparam logic [CW-1:0] MAX_L   = CW'(MAX_LANES);

    logic [7:0]    fifo_mem [BUF_BYTES];
    logic [PW-1:0] rd_ptr_reg, wr_ptr_reg;
    logic [CW-1:0] count_reg, count_next;
    logic [CW-1:0] l_reg, l_next, l_req;
    logic          tail_held_reg, tail_held_next;
    logic          strb_err_reg;

    logic [CW-1:0] strb_bytes, push_amt, pop_amt, beat_k;
    logic          strb_legal, accept_in, push_en, beat_valid, pop_en;

    // Decode the strobe into a byte count; only contiguous-from-bit-0 patterns are legal
    always_comb begin
        strb_legal = 1'b1;
        strb_bytes = '0;
        case (rpck_write_strb)
            4'b0001: strb_bytes = CW'(1);
            4'b0011: strb_bytes = CW'(2);
            4'b0111: strb_bytes = CW'(3);
            4'b1111: strb_bytes = CW'(4);
            default: strb_legal = 1'b0;
        endcase
    end

    // Input ready depends only on registered state, so there is no loop through rpck_write_rqst
    assign rpck_data_rqst = !tail_held_reg && ((BUF_CNT - count_reg) >= CW'(4));
    assign accept_in      = rpck_write_rqst && rpck_data_rqst;
    assign push_en        = accept_in && strb_legal;
    assign push_amt       = push_en ? strb_bytes : '0;

    // Without the packet end buffered, 2L bytes are needed so the last flags are decidable
    assign beat_valid = (tail_held_reg && (count_reg != '0)) || (count_reg >= (l_reg << 1));
    assign beat_k     = (count_reg < l_reg) ? count_reg : l_reg;
    assign pop_en     = beat_valid && ln_data_rqst;
    assign pop_amt    = pop_en ? beat_k : '0;

    // Next-state arithmetic for occupancy, packet-end tracking and lane count
    always_comb begin
        l_req          = {{(CW-2){1'b0}}, lanes_number} + CW'(1);
        count_next     = count_reg + push_amt - pop_amt;
        tail_held_next = (tail_held_reg || (accept_in && rpck_last_word)) && (count_next != '0);
        l_next         = l_reg;
        if (count_reg == '0) begin
            l_next = (l_req > MAX_L) ? MAX_L : l_req;
        end
    end

    // Control state: pointers, count, tail flag, latched lane count and sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_reg    <= '0;
            wr_ptr_reg    <= '0;
            count_reg     <= '0;
            tail_held_reg <= 1'b0;
            l_reg         <= CW'(1);
            strb_err_reg  <= 1'b0;
        end else begin
            rd_ptr_reg    <= rd_ptr_reg + pop_amt[PW-1:0];
            wr_ptr_reg    <= wr_ptr_reg + push_amt[PW-1:0];
            count_reg     <= count_next;
            tail_held_reg <= tail_held_next;
            l_reg         <= l_next;
            if (accept_in && !strb_legal) begin
                strb_err_reg <= 1'b1;
            end
        end
    end

    // Byte storage: strobed bytes land at consecutive slots starting at the write pointer
    always_ff @(posedge clk) begin
        for (int j = 0; j < 4; j++) begin
            if (push_en && rpck_write_strb[j]) begin
                fifo_mem[wr_ptr_reg + PW'(j)] <= rpck_write_data[8*j +: 8];
            end
        end
    end

    assign strb_err = strb_err_reg;

    genvar gi;
    generate
        for (gi = 0; gi < MAX_LANES; gi++) begin : g_lane
            logic lane_on;
            // Lane gi carries FIFO byte gi of the beat; idle lanes are driven to zero
            always_comb begin
                lane_on                   = beat_valid && (CW'(gi) < beat_k);
                ln_write_rqst[gi]         = lane_on;
                ln_write_data[8*gi +: 8]  = lane_on ? fifo_mem[rd_ptr_reg + PW'(gi)] : 8'h00;
                ln_last_word[gi]          = lane_on && tail_held_reg &&
                                            (count_reg <= (l_reg + CW'(gi)));
            end
        end
    endgenerate

endmodule

// File: tb/tb_repacker_n_lanes.sv
// Self-checking bench for repacker_n_lanes: byte-queue reference model compared
// every cycle, directed scenarios pinned by literal beat logs, then random traffic.
module tb_repacker_n_lanes;

    localparam int ML  = 4;
    localparam int BUF = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    lanes_number;
    logic          ln_data_rqst;
    logic [8*ML-1:0] ln_write_data;
    logic [ML-1:0] ln_write_rqst;
    logic [ML-1:0] ln_last_word;
    logic [31:0]   rpck_write_data;
    logic [3:0]    rpck_write_strb;
    logic          rpck_write_rqst;
    logic          rpck_last_word;
    logic          rpck_data_rqst;
    logic          strb_err;

    repacker_n_lanes #(.MAX_LANES(ML), .BUF_BYTES(BUF)) dut (
        .clk(clk), .rst(rst), .lanes_number(lanes_number), .ln_data_rqst(ln_data_rqst),
        .ln_write_data(ln_write_data), .ln_write_rqst(ln_write_rqst), .ln_last_word(ln_last_word),
        .rpck_write_data(rpck_write_data), .rpck_write_strb(rpck_write_strb),
        .rpck_write_rqst(rpck_write_rqst), .rpck_last_word(rpck_last_word),
        .rpck_data_rqst(rpck_data_rqst), .strb_err(strb_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: packet bytes still owed to the lanes, in wire order
    logic [7:0] mq[$];
    bit  m_tail, m_err, m_acc;
    int  m_L;

    typedef struct packed { logic [31:0] d; logic [3:0] wr; logic [3:0] lst; } beat_t;
    beat_t blog[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_exp(output logic [31:0] d, output logic [3:0] wr,
                                      output logic [3:0] lst, output bit rdy);
        int n = mq.size();
        int k;
        bit bv;
        rdy = !m_tail && (BUF - n >= 4);
        bv  = (m_tail && n > 0) || (n >= 2 * m_L);
        k   = bv ? ((n < m_L) ? n : m_L) : 0;
        d = '0; wr = '0; lst = '0;
        for (int i = 0; i < k; i++) begin
            wr[i]      = 1'b1;
            d[8*i +: 8] = mq[i];
            if (m_tail && n <= m_L + i) lst[i] = 1'b1;
        end
    endfunction

    task automatic check_cycle();
        logic [31:0] d; logic [3:0] wr, lst; bit rdy;
        model_exp(d, wr, lst, rdy);
        chk("ln_write_rqst", 32'(ln_write_rqst), 32'(wr));
        chk("ln_write_data", ln_write_data, d);
        chk("ln_last_word", 32'(ln_last_word), 32'(lst));
        chk("rpck_data_rqst", 32'(rpck_data_rqst), 32'(rdy));
        chk("strb_err", 32'(strb_err), 32'(m_err));
        if (ln_data_rqst && (ln_write_rqst != '0))
            blog.push_back('{ln_write_data, ln_write_rqst, ln_last_word});
    endtask

    task automatic model_update();
        logic [31:0] d; logic [3:0] wr, lst; bit rdy;
        int n0;
        if (rst) begin
            mq.delete(); m_tail = 0; m_err = 0; m_L = 1; m_acc = 0;
            return;
        end
        model_exp(d, wr, lst, rdy);
        n0 = mq.size();
        if (ln_data_rqst && wr != '0)
            for (int i = 0; i < $countones(wr); i++) void'(mq.pop_front());
        m_acc = rpck_write_rqst && rdy;
        if (m_acc) begin
            if (rpck_write_strb inside {4'h1, 4'h3, 4'h7, 4'hF}) begin
                for (int j = 0; j < $countones(rpck_write_strb); j++)
                    mq.push_back(rpck_write_data[8*j +: 8]);
            end else begin
                m_err = 1;
            end
            if (rpck_last_word) m_tail = 1;
        end
        if (n0 == 0) m_L = (int'(lanes_number) + 1 > ML) ? ML : int'(lanes_number) + 1;
        if (mq.size() == 0) m_tail = 0;
        if (mq.size() > BUF) begin
            n_fail++;
            $display("FAIL occupancy: got %0d expected <= %0d", mq.size(), BUF);
        end
    endtask

    // one clock: compare at the falling edge, advance the model at the rising edge
    task automatic step();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic push_word(input logic [31:0] d, input logic [3:0] s, input logic l);
        int t = 0;
        rpck_write_data = d; rpck_write_strb = s; rpck_last_word = l; rpck_write_rqst = 1'b1;
        do begin
            step();
            t++;
        end while (!m_acc && t < 64);
        if (!m_acc) chk("push_timeout", 32'(t), 32'(0));
        rpck_write_rqst = 1'b0; rpck_last_word = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((mq.size() != 0 || m_tail) && t < 100) begin
            step();
            t++;
        end
        if (t >= 100) chk("drain_timeout", 32'(mq.size()), 32'(0));
        step();
    endtask

    task automatic chk_beat(input int idx, input beat_t exp);
        beat_t act;
        act = (idx < blog.size()) ? blog[idx] : '1;
        chk($sformatf("beat%0d", idx), act.d, exp.d);
        chk($sformatf("beat%0d_wr", idx), 32'(act.wr), 32'(exp.wr));
        chk($sformatf("beat%0d_last", idx), 32'(act.lst), 32'(exp.lst));
    endtask

    task automatic do_reset();
        rst = 1'b1; step(); step(); rst = 1'b0;
    endtask

    initial begin
        int nb;
        logic [3:0] strbs [7];
        strbs = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hF, 4'hF, 4'h5};
        rst = 1'b1; lanes_number = 2'd0; ln_data_rqst = 1'b0;
        rpck_write_data = '0; rpck_write_strb = '0; rpck_write_rqst = 1'b0; rpck_last_word = 1'b0;
        m_L = 1;
        do_reset();
        chk("reset_wr", 32'(ln_write_rqst), 32'h0);
        chk("reset_data", ln_write_data, 32'h0);
        chk("reset_last", 32'(ln_last_word), 32'h0);
        chk("reset_err", 32'(strb_err), 32'h0);
        chk("reset_rdy", 32'(rpck_data_rqst), 32'h1);

        // L=4: 6-byte packet
        lanes_number = 2'd3; ln_data_rqst = 1'b1; blog.delete();
        push_word(32'h44332211, 4'hF, 1'b0);
        push_word(32'h00006655, 4'h3, 1'b1);
        drain();
        chk_beat(0, '{32'h44332211, 4'b1111, 4'b1100});
        chk_beat(1, '{32'h00006655, 4'b0011, 4'b0011});
        chk("t1_rdy_after", 32'(rpck_data_rqst), 32'h1);

        // L=2: 5-byte packet
        lanes_number = 2'd1; blog.delete();
        push_word(32'hDDCCBBAA, 4'hF, 1'b0);
        push_word(32'h000000EE, 4'h1, 1'b1);
        drain();
        chk_beat(0, '{32'h0000BBAA, 4'b0011, 4'b0000});
        chk_beat(1, '{32'h0000DDCC, 4'b0011, 4'b0010});
        chk_beat(2, '{32'h000000EE, 4'b0001, 4'b0001});

        // L=1: 3-byte packet
        lanes_number = 2'd0; blog.delete();
        push_word(32'h00332211, 4'h7, 1'b1);
        drain();
        chk_beat(0, '{32'h00000011, 4'b0001, 4'b0000});
        chk_beat(1, '{32'h00000022, 4'b0001, 4'b0000});
        chk_beat(2, '{32'h00000033, 4'b0001, 4'b0001});

        // L=4 with lanes stalled: fill until ready drops, hold, then release
        lanes_number = 2'd3; ln_data_rqst = 1'b0; blog.delete();
        for (int w = 0; w < 4; w++) push_word(32'h10203040 + 32'(w), 4'hF, 1'b0);
        rpck_write_data = 32'h000000AB; rpck_write_strb = 4'h1; rpck_last_word = 1'b1;
        rpck_write_rqst = 1'b1;
        for (int c = 0; c < 10; c++) step();
        chk("stall_rdy", 32'(rpck_data_rqst), 32'h0);
        chk("stall_wr", 32'(ln_write_rqst), 32'hF);
        chk("stall_data", ln_write_data, 32'h10203040);
        ln_data_rqst = 1'b1;
        push_word(32'h000000AB, 4'h1, 1'b1);
        drain();
        nb = 0;
        foreach (blog[i]) nb += $countones(blog[i].wr);
        chk("stall_bytes", 32'(nb), 32'd17);

        // illegal strobe drops the word but still ends the packet
        blog.delete();
        push_word(32'h87654321, 4'hF, 1'b0);
        push_word(32'hFFFFFFFF, 4'h5, 1'b1);
        chk("err_set", 32'(strb_err), 32'h1);
        drain();
        chk_beat(0, '{32'h87654321, 4'b1111, 4'b1111});
        chk("err_sticky", 32'(strb_err), 32'h1);

        // reset mid-packet with 6 bytes buffered
        ln_data_rqst = 1'b0;
        push_word(32'h0BADF00D, 4'hF, 1'b0);
        push_word(32'h0000CAFE, 4'h3, 1'b0);
        rst = 1'b1; step(); rst = 1'b0;
        chk("mid_rst_wr", 32'(ln_write_rqst), 32'h0);
        chk("mid_rst_last", 32'(ln_last_word), 32'h0);
        chk("mid_rst_rdy", 32'(rpck_data_rqst), 32'h1);
        chk("mid_rst_err", 32'(strb_err), 32'h0);
        ln_data_rqst = 1'b1; blog.delete();
        push_word(32'h04030201, 4'hF, 1'b1);
        drain();
        chk_beat(0, '{32'h04030201, 4'b1111, 4'b1111});
        chk("mid_rst_nbeats", 32'(blog.size()), 32'd1);

        // randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            rst             = ($urandom_range(0, 499) == 0);
            lanes_number    = 2'($urandom_range(0, 3));
            ln_data_rqst    = ($urandom_range(0, 9) < 7);
            rpck_write_rqst = ($urandom_range(0, 9) < 6);
            rpck_write_data = $urandom;
            rpck_write_strb = ($urandom_range(0, 49) == 0) ? strbs[6] : strbs[$urandom_range(0, 5)];
            rpck_last_word  = ($urandom_range(0, 4) == 0);
            step();
        end
        rst = 1'b0; rpck_write_rqst = 1'b0; ln_data_rqst = 1'b1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
